wfg_stim_mem_arb: RTL and testbench
===================================

# wfg_stim_mem_arb

Round-robin arbiter sharing the single read port of the stimulus SRAM (`csb1`/`addr1`/`dout1`) between `NUM_CH` stimulus-memory channels and an optional host read port. Sits between the per-channel stimulus readers and the OpenRAM macro. Issues at most one SRAM read per cycle and routes the returned word back to the granted requester with a fixed latency.

## Interface
- `NUM_CH`, 2: number of channel requesters (2..8).
- `ADDR_W`, 10: SRAM word address width.
- `DATA_W`, 32: SRAM data width.
- `MEM_LAT`, 1: SRAM read latency in cycles, from the capturing edge to valid `dout1` (1..3).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `en_i`  in  1  arbiter enable.
- `ch_req_i`  in  NUM_CH  per-channel read request; level, held until granted.
- `ch_addr_i`  in  NUM_CH*ADDR_W  per-channel address; channel k at bits [k*ADDR_W +: ADDR_W].
- `ch_gnt_o`  out  NUM_CH  one-hot grant pulse.
- `ch_rvalid_o`  out  NUM_CH  one-hot read-data valid pulse.
- `rdata_o`  out  DATA_W  returned word, shared by all requesters.
- `host_req_i` / `host_addr_i` / `host_gnt_o` / `host_rvalid_o`  in/in/out/out  1/ADDR_W/1/1  host port; present only with the macro.
- `busy_o`  out  1  high while any read is in flight.
- `csb1`  out  1  SRAM chip select, active-low.
- `addr1`  out  ADDR_W  SRAM address.
- `dout1`  in  DATA_W  SRAM read data.

## Operation
- FSM states: ST_IDLE, ST_RUN, ST_DRAIN.
  - ST_IDLE -> ST_RUN when `en_i`=1.
  - ST_RUN -> ST_DRAIN when `en_i`=0 and reads are in flight.
  - ST_RUN -> ST_IDLE when `en_i`=0 and nothing is in flight.
  - ST_DRAIN -> ST_IDLE when the in-flight pipeline is empty. `en_i` re-asserting during ST_DRAIN has no effect until ST_IDLE is reached.
- Grants are issued only in ST_RUN.
- Each cycle in ST_RUN, select at most one requester among the asserted `ch_req_i`:
  - Round-robin order starts at `rr_ptr`. After a grant to channel k, `rr_ptr` = (k+1) mod NUM_CH.
  - `rr_ptr` resets to 0. It is unchanged in cycles with no grant.
- A lone requester may be granted every cycle.
- Requests are level-sensitive. A `ch_req_i` still high at the edge ending its grant cycle is a new request.
- Dropping `req` before it is granted is legal. That request is discarded; no grant and no rvalid are produced for it.
- In-flight tracking: a `MEM_LAT+1`-deep shift register of {valid, requester id}. `busy_o` = OR of the valid bits.
- Read data is routed only to the requester whose id reaches the end of the pipeline. `rdata_o` holds its last value between pulses.
- Addresses are passed through unmodified; no range check.

## Timing
- Request sampled high at edge E0 and selected: during E0..E1 `ch_gnt_o[k]`=1, `csb1`=0 and `addr1`=the channel's address, all registered.
- SRAM captures the address at E1. The arbiter registers `dout1` at E1+MEM_LAT.
- `ch_rvalid_o[k]` and `rdata_o` are valid for one cycle after that edge: `MEM_LAT+1` cycles after the grant cycle.
- Idle cycles: `csb1`=1 and `addr1` holds its last value.
- Reset values: `csb1`=1, `addr1`=0, `ch_gnt_o`=0, `ch_rvalid_o`=0, `rdata_o`=0, `busy_o`=0, `host_gnt_o`=0, `host_rvalid_o`=0, state ST_IDLE.
- Reset mid-operation: the in-flight pipeline is cleared. No rvalid pulse follows the reset edge.

## Configuration
- Macro: `WFG_STIM_MEM_ARB_HOST_EN`.
- Defined: host port present and takes priority over all channels, with a starvation guard:
  - After a host grant, if any channel is requesting, the next cycle grants a channel.
  - Host grants do not move `rr_ptr`.
  - `host_rvalid_o` has the same latency as channel rvalid.
- Undefined: host ports are absent and only the channels arbitrate.

## Structure
- Package `wfg_stim_mem_arb_pkg`:
  - state enum `wfg_stim_mem_arb_states_t`;
  - the host id constant (`NUM_CH` encoding);
  - default width constants for ADDR_W and DATA_W.
- Sub-module `wfg_rr_pick`: combinational round-robin picker. Takes request vector + pointer, returns one-hot grant + index; parameterised by width.

## Test plan
- Single channel: `ch_req_i`=01, addr 0x005, SRAM model word 5 = 0xDEAD_BEEF -> gnt cycle T, `csb1`=0/`addr1`=5 in T, `ch_rvalid_o`=01 with `rdata_o`=0xDEAD_BEEF in T+2 (MEM_LAT=1).
- Both channels held high for 6 cycles -> grants alternate 01,10,01,10,01,10 and `csb1`=0 every cycle.
- `en_i` dropped in the cycle after a grant -> no further grants, rvalid still delivered, `busy_o` falls, state returns to ST_IDLE.
- Channel 1 drops its request before being granted while channel 0 is granted -> no grant or rvalid for channel 1, and `rr_ptr`=1.
- `rst_n`=0 for one cycle while two reads are in flight -> no rvalid afterwards, all outputs at their reset values.
- With `WFG_STIM_MEM_ARB_HOST_EN`, host and channel 0 continuously requesting -> grants alternate host/ch0, and `host_rvalid_o` arrives 2 cycles after each host grant.

Source files
------------

// File: rtl/wfg_stim_mem_arb_pkg.sv
// Shared types and constants for the stimulus-SRAM read arbiter.
// Purely declarative: no logic, no latency, no flow control.
// The host requester id is encoded as NUM_CH, one past the last channel.
package wfg_stim_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wfg_stim_mem_arb_states_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    function automatic int host_id(input int num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/wfg_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// Latency: zero (pure combinational).
// No backpressure; any=0 when no request is asserted.
module wfg_rr_pick #(
    parameter int W  = 2,
    parameter int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < W; i++) begin
            j = int'(ptr) + i;
            if (j >= W) j = j - W;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/wfg_stim_mem_arb.sv
// Round-robin arbiter sharing the stimulus SRAM read port; optional host port via WFG_STIM_MEM_ARB_HOST_EN.
// Latency: grant registered in the request cycle's next edge, rvalid/rdata MEM_LAT+1 cycles after the grant cycle.
// Backpressure: level requests held until granted; at most one SRAM read per cycle.
module wfg_stim_mem_arb
    import wfg_stim_mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    output logic [NUM_CH-1:0]        ch_gnt_o,
    output logic [NUM_CH-1:0]        ch_rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
`ifdef WFG_STIM_MEM_ARB_HOST_EN
    input  logic                     host_req_i,
    input  logic [ADDR_W-1:0]        host_addr_i,
    output logic                     host_gnt_o,
    output logic                     host_rvalid_o,
`endif
    output logic                     busy_o,
    output logic                     csb1,
    output logic [ADDR_W-1:0]        addr1,
    input  logic [DATA_W-1:0]        dout1
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ID_W  = $clog2(NUM_CH + 1);
    localparam logic [ID_W-1:0] HOST_ID = ID_W'(host_id(NUM_CH));

    wfg_stim_mem_arb_states_t state, state_nxt;

    logic [PTR_W-1:0]  rr_ptr;
    logic [NUM_CH-1:0] pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    logic              host_req_l;
    logic [ADDR_W-1:0] host_addr_l;
    logic              last_host;
    logic              host_win;

    logic              sel_vld;
    logic              sel_host;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;

    logic [MEM_LAT:0]  pipe_vld;
    logic [ID_W-1:0]   pipe_id [0:MEM_LAT];
    logic [NUM_CH-1:0] rv_dec;

`ifdef WFG_STIM_MEM_ARB_HOST_EN
    assign host_req_l  = host_req_i;
    assign host_addr_l = host_addr_i;
`else
    assign host_req_l  = 1'b0;
    assign host_addr_l = '0;
`endif

    // Host wins unless it was served last cycle and a channel is waiting.
    assign host_win = host_req_l && !(last_host && pick_any);
    assign busy_o   = |pipe_vld;

    wfg_rr_pick #(.W(NUM_CH), .PW(PTR_W)) u_pick (
        .req (ch_req_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en_i) state_nxt = ST_RUN;
            ST_RUN:   if (!en_i) state_nxt = busy_o ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (!busy_o) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_host = 1'b0;
        sel_id   = '0;
        sel_addr = '0;
        if (state == ST_RUN && en_i) begin
            if (host_win) begin
                sel_vld  = 1'b1;
                sel_host = 1'b1;
                sel_id   = HOST_ID;
                sel_addr = host_addr_l;
            end else if (pick_any) begin
                sel_vld  = 1'b1;
                sel_id   = ID_W'(pick_idx);
                sel_addr = ch_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rv_dec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rv_dec[k] = pipe_vld[MEM_LAT] && (pipe_id[MEM_LAT] == ID_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            last_host   <= 1'b0;
            csb1        <= 1'b1;
            addr1       <= '0;
            ch_gnt_o    <= '0;
            ch_rvalid_o <= '0;
            rdata_o     <= '0;
            pipe_vld    <= '0;
            for (int i = 0; i <= MEM_LAT; i++) pipe_id[i] <= '0;
`ifdef WFG_STIM_MEM_ARB_HOST_EN
            host_gnt_o    <= 1'b0;
            host_rvalid_o <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            csb1        <= !sel_vld;
            if (sel_vld) addr1 <= sel_addr;
            ch_gnt_o    <= (sel_vld && !sel_host) ? pick_gnt : '0;
            ch_rvalid_o <= rv_dec;
            if (pipe_vld[MEM_LAT]) rdata_o <= dout1;
            // Stage MEM_LAT lines up with the edge at which dout1 is valid.
            pipe_vld    <= {pipe_vld[MEM_LAT-1:0], sel_vld};
            pipe_id[0]  <= sel_id;
            for (int i = 1; i <= MEM_LAT; i++) pipe_id[i] <= pipe_id[i-1];
            last_host   <= sel_vld && sel_host;
            if (sel_vld && !sel_host) begin
                rr_ptr <= (int'(pick_idx) == NUM_CH - 1) ? '0 : pick_idx + 1'b1;
            end
`ifdef WFG_STIM_MEM_ARB_HOST_EN
            host_gnt_o    <= sel_vld && sel_host;
            host_rvalid_o <= pipe_vld[MEM_LAT] && (pipe_id[MEM_LAT] == HOST_ID);
`endif
        end
    end

endmodule

// File: tb/tb_wfg_stim_mem_arb.sv
// Scoreboard bench for wfg_stim_mem_arb (NUM_CH=2, MEM_LAT=1) with a behavioural SRAM.
// Stimulus pushes expected grants/read returns with their cycle; a negedge monitor pops and compares.
module tb_wfg_stim_mem_arb;
    import wfg_stim_mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en_i;
    logic [1:0]      ch_req_i;
    logic [2*AW-1:0] ch_addr_i;
    logic [1:0]      ch_gnt_o;
    logic [1:0]      ch_rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            busy_o;
    logic            csb1;
    logic [AW-1:0]   addr1;
    logic [DW-1:0]   dout1 = '0;
    logic            host_gnt_w;
    logic            host_rv_w;
`ifdef WFG_STIM_MEM_ARB_HOST_EN
    logic            host_req_i;
    logic [AW-1:0]   host_addr_i;
    logic            host_gnt_o;
    logic            host_rvalid_o;
    assign host_gnt_w = host_gnt_o;
    assign host_rv_w  = host_rvalid_o;
`else
    assign host_gnt_w = 1'b0;
    assign host_rv_w  = 1'b0;
`endif

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t gq[$];
    exp_t rq[$];

    wfg_stim_mem_arb #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .ch_req_i     (ch_req_i),
        .ch_addr_i    (ch_addr_i),
        .ch_gnt_o     (ch_gnt_o),
        .ch_rvalid_o  (ch_rvalid_o),
        .rdata_o      (rdata_o),
`ifdef WFG_STIM_MEM_ARB_HOST_EN
        .host_req_i   (host_req_i),
        .host_addr_i  (host_addr_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
`endif
        .busy_o       (busy_o),
        .csb1         (csb1),
        .addr1        (addr1),
        .dout1        (dout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return (a == 10'd5) ? 32'hDEAD_BEEF : {22'h2A5A5A, a};
    endfunction

    // SRAM: captures address with csb1 low, data valid one cycle later.
    always @(posedge clk) if (!csb1) dout1 <= word(addr1);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input int id, input logic [31:0] a, input int c);
        exp_t e;
        e.id = id; e.val = a; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_rd(input int id, input logic [31:0] d, input int c);
        exp_t e;
        e.id = id; e.val = d; e.cyc = c;
        rq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_csb1", 64'(csb1), 64'd1);
        chk("rst_addr1", 64'(addr1), 64'd0);
        chk("rst_gnt", 64'({host_gnt_w, ch_gnt_o}), 64'd0);
        chk("rst_rvalid", 64'({host_rv_w, ch_rvalid_o}), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if ((|ch_gnt_o) || host_gnt_w) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 64'({host_gnt_w, ch_gnt_o}), 64'd0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_vec", 64'({host_gnt_w, ch_gnt_o}), 64'(1) << e.id);
                    chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                    chk("gnt_addr1", 64'(addr1), 64'(e.val));
                    chk("gnt_csb1", 64'(csb1), 64'd0);
                end
            end else begin
                chk("idle_csb1", 64'(csb1), 64'd1);
            end
            if ((|ch_rvalid_o) || host_rv_w) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 64'({host_rv_w, ch_rvalid_o}), 64'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rv_vec", 64'({host_rv_w, ch_rvalid_o}), 64'(1) << e.id);
                    chk("rv_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rv_data", 64'(rdata_o), 64'(e.val));
                end
            end
        end
    end

    initial begin
        int c;
        int a;
        rst_n     = 1'b0;
        en_i      = 1'b0;
        ch_req_i  = '0;
        ch_addr_i = '0;
`ifdef WFG_STIM_MEM_ARB_HOST_EN
        host_req_i  = 1'b0;
        host_addr_i = '0;
`endif
        step(2);
        check_reset();
        rst_n = 1'b1;
        en_i  = 1'b1;
        step(2);
        chk("state_run", 64'(dut.state), 64'(ST_RUN));

        // Both channels held for six cycles: strict alternation from rr_ptr=0.
        c = cyc;
        for (int i = 0; i < 6; i++) begin
            ch_req_i  = 2'b11;
            ch_addr_i = {10'(32'h20 + i), 10'(32'h10 + i)};
            a = (i % 2 == 1) ? 32'h20 + i : 32'h10 + i;
            push_gnt(i % 2, 32'(a), c + 1 + i);
            push_rd(i % 2, word(10'(a)), c + 3 + i);
            step(1);
        end
        ch_req_i = '0;
        step(4);
        chk("rr_ptr_after_alt", 64'(dut.rr_ptr), 64'd0);

        // Channel 1 withdraws while channel 0 is granted.
        c = cyc;
        ch_req_i  = 2'b11;
        ch_addr_i = {10'h031, 10'h030};
        push_gnt(0, 32'h30, c + 1);
        push_rd(0, word(10'h030), c + 3);
        step(1);
        ch_req_i = '0;
        step(4);
        chk("rr_ptr_after_drop", 64'(dut.rr_ptr), 64'd1);

        // Single channel 0 read of word 5.
        c = cyc;
        ch_req_i  = 2'b01;
        ch_addr_i = {10'h000, 10'h005};
        push_gnt(0, 32'h5, c + 1);
        push_rd(0, 32'hDEAD_BEEF, c + 3);
        step(1);
        ch_req_i = '0;
        step(4);

        // en_i dropped during the grant cycle with the request still held.
        c = cyc;
        ch_req_i  = 2'b01;
        ch_addr_i = {10'h000, 10'h007};
        push_gnt(0, 32'h7, c + 1);
        push_rd(0, word(10'h007), c + 3);
        step(1);
        en_i = 1'b0;
        step(1);
        chk("drain_state", 64'(dut.state), 64'(ST_DRAIN));
        chk("drain_busy", 64'(busy_o), 64'd1);
        step(2);
        chk("idle_state", 64'(dut.state), 64'(ST_IDLE));
        chk("idle_busy", 64'(busy_o), 64'd0);
        step(2);
        ch_req_i = '0;
        en_i     = 1'b1;
        step(2);

        // Reset with two reads in flight: ch1 (rr_ptr=1) then ch0.
        c = cyc;
        ch_req_i  = 2'b11;
        ch_addr_i = {10'h041, 10'h040};
        push_gnt(1, 32'h41, c + 1);
        push_gnt(0, 32'h40, c + 2);
        step(2);
        rst_n    = 1'b0;
        ch_req_i = '0;
        step(1);
        check_reset();
        rst_n = 1'b1;
        step(5);

`ifdef WFG_STIM_MEM_ARB_HOST_EN
        // Host and channel 0 both continuously requesting.
        c = cyc;
        host_req_i  = 1'b1;
        host_addr_i = 10'h050;
        ch_req_i    = 2'b01;
        ch_addr_i   = {10'h000, 10'h060};
        push_gnt(2, 32'h50, c + 1);
        push_gnt(0, 32'h60, c + 2);
        push_gnt(2, 32'h50, c + 3);
        push_gnt(0, 32'h60, c + 4);
        push_rd(2, word(10'h050), c + 3);
        push_rd(0, word(10'h060), c + 4);
        push_rd(2, word(10'h050), c + 5);
        push_rd(0, word(10'h060), c + 6);
        step(4);
        host_req_i = 1'b0;
        ch_req_i   = '0;
        step(5);
`endif

        chk("gnt_queue_empty", 64'(gq.size()), 64'd0);
        chk("rd_queue_empty", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
